// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub, iterative shift-add multiply and restoring divide/modulo.
// Optional SEQ_ALU_ABORT_EN adds an abort input that drops CALC/DONE back to IDLE.
module seq_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef SEQ_ALU_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [1:0]           error
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_DIV = 4'h4;
  localparam logic [3:0] OP_MOD = 4'h5;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     sh_q, sh_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic [1:0]           error_q, error_d;

  logic [WIDTH:0]       sum, diff;
  logic [2*WIDTH-1:0]   acc_mul;
  logic [WIDTH:0]       rem_shift, rem_sub;
  logic                 rem_ge;
  logic [WIDTH-1:0]     rem_next, quot_next;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign error     = error_q;

  always_comb begin
    sum  = {1'b0, operand_a} + {1'b0, operand_b};
    diff = {1'b0, operand_a} - {1'b0, operand_b};

    // Multiply: sh_q holds the remaining multiplier bits, mcand_q the shifted multiplicand.
    acc_mul = acc_q + (sh_q[0] ? mcand_q : '0);

    // Restoring divide: sh_q shifts the dividend out MSB first and the quotient in LSB first;
    // acc_q low bits hold the partial remainder, always < divisor.
    rem_shift = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, b_q};
    rem_ge    = ~rem_sub[WIDTH];
    rem_next  = rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quot_next = {sh_q[WIDTH-2:0], rem_ge};
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    b_d      = b_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    error_d  = error_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = opcode;
          b_d     = operand_b;
          cnt_d   = '0;
          state_d = DONE;
          case (opcode)
            OP_ADD: begin
              result_d = {{(WIDTH-1){1'b0}}, sum};
              error_d  = {1'b0, sum[WIDTH]};
            end
            OP_SUB: begin
              result_d = {{WIDTH{diff[WIDTH]}}, diff[WIDTH-1:0]};
              error_d  = {1'b0, diff[WIDTH]};
            end
            OP_MUL: begin
              acc_d   = '0;
              mcand_d = {{WIDTH{1'b0}}, operand_a};
              sh_d    = operand_b;
              state_d = CALC;
            end
            OP_DIV, OP_MOD: begin
              if (operand_b == '0) begin
                result_d = (opcode == OP_DIV) ? '1 : {{WIDTH{1'b0}}, operand_a};
                error_d  = 2'b10;
              end else begin
                acc_d   = '0;
                sh_d    = operand_a;
                state_d = CALC;
              end
            end
            default: begin
              result_d = '0;
              error_d  = 2'b00;
            end
          endcase
        end
      end

      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          acc_d   = acc_mul;
          mcand_d = mcand_q << 1;
          sh_d    = sh_q >> 1;
        end else begin
          acc_d = {{WIDTH{1'b0}}, rem_next};
          sh_d  = quot_next;
        end
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
          error_d = 2'b00;
          if (op_q == OP_MUL)
            result_d = acc_mul;
          else if (op_q == OP_DIV)
            result_d = {{WIDTH{1'b0}}, quot_next};
          else
            result_d = {{WIDTH{1'b0}}, rem_next};
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

`ifdef SEQ_ALU_ABORT_EN
    // Abort discards any in-flight work but leaves the last published result untouched.
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
      error_d  = error_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      error_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=16): driver pushes expected results, monitor pops on handshake.
module tb_seq_alu;

  localparam int unsigned W = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      opcode;
  logic [W-1:0]    operand_a, operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  result;
  logic [1:0]      error;
`ifdef SEQ_ALU_ABORT_EN
  logic            abort = 1'b0;
`endif

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef SEQ_ALU_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .opcode(opcode),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] res;
    logic [1:0]     err;
    int             lat;
    int             acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   prev_hs = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: compare every result handshake against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (prev_hs) chk("one_cycle_valid", {63'b0, out_valid}, 64'd0);
    prev_hs = 1'b0;
    if (rst_n && out_valid && out_ready) begin
      prev_hs = 1'b1;
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result", {32'b0, result}, {32'b0, e.res});
        chk("error", {62'b0, error}, {62'b0, e.err});
        if (e.lat >= 0)
          chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] r, input logic [1:0] er, input int lat, input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'd0, 64'd1);
      return;
    end
    in_valid  = 1'b1;
    opcode    = op;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
    if (push) sb.push_back('{res: r, err: er, lat: lat, acc: cyc});
    in_valid  = 1'b0;
    opcode    = 4'h0;
    operand_a = '0;
    operand_b = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    opcode    = 4'h0;
    operand_a = '0;
    operand_b = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_result", {32'b0, result}, 64'd0);
    chk("rst_error", {62'b0, error}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(4'h1, 16'h0003, 16'h0001, 32'h0000_0004, 2'b00, 1,  1'b1);
    issue(4'h2, 16'h0001, 16'h0003, 32'hFFFF_FFFE, 2'b01, 1,  1'b1);
    issue(4'h1, 16'hFFFF, 16'h0001, 32'h0001_0000, 2'b01, 1,  1'b1);
    issue(4'h2, 16'h0005, 16'h0003, 32'h0000_0002, 2'b00, 1,  1'b1);
    issue(4'h3, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 2'b00, 17, 1'b1);
    issue(4'h3, 16'h1234, 16'h0010, 32'h0001_2340, 2'b00, 17, 1'b1);
    issue(4'h3, 16'h0000, 16'hABCD, 32'h0000_0000, 2'b00, 17, 1'b1);
    issue(4'h4, 16'd100,  16'd7,    32'h0000_000E, 2'b00, 17, 1'b1);
    issue(4'h5, 16'd100,  16'd7,    32'h0000_0002, 2'b00, 17, 1'b1);
    issue(4'h4, 16'hFFFF, 16'h0001, 32'h0000_FFFF, 2'b00, 17, 1'b1);
    issue(4'h5, 16'hFFFF, 16'h0100, 32'h0000_00FF, 2'b00, 17, 1'b1);
    issue(4'h4, 16'd3,    16'd7,    32'h0000_0000, 2'b00, 17, 1'b1);
    issue(4'h5, 16'd3,    16'd7,    32'h0000_0003, 2'b00, 17, 1'b1);
    issue(4'h4, 16'd5,    16'd0,    32'hFFFF_FFFF, 2'b10, 1,  1'b1);
    issue(4'h5, 16'd5,    16'd0,    32'h0000_0005, 2'b10, 1,  1'b1);
    issue(4'h7, 16'd5,    16'd5,    32'h0000_0000, 2'b00, 1,  1'b1);
    drain();

    // Back-pressure: result must hold while a new request waits.
    out_ready = 1'b0;
    issue(4'h1, 16'h0010, 16'h0020, 32'h0000_0030, 2'b00, -1, 1'b1);
    in_valid  = 1'b1;
    opcode    = 4'h1;
    operand_a = 16'h0001;
    operand_b = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", {63'b0, out_valid}, 64'd1);
      chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
      chk("stall_result", {32'b0, result}, 64'h30);
      chk("stall_error", {62'b0, error}, 64'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("release_in_ready", {63'b0, in_ready}, 64'd1);
    drain();

    // Reset in the middle of a multiply discards it.
    issue(4'h3, 16'h1234, 16'h5678, 32'h0, 2'b00, -1, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("midrst_result", {32'b0, result}, 64'd0);
    chk("midrst_error", {62'b0, error}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'h3, 16'd3, 16'd1, 32'h0000_0003, 2'b00, 17, 1'b1);
    drain();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
